// File: rtl/pwm_capture.sv
// pwm_capture: single-channel PWM input decoder measuring high time and period.
// Optional 3-sample glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    input  logic       enable,
    input  logic [3:0] prescale_div,
    input  logic       clr_overflow,
    output logic [7:0] high_time,
    output logic [7:0] period,
    output logic       sample_valid,
    output logic       level_static,
    output logic       overflow
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    logic [0:0]  state;
    logic        s1, s2, s3;
    logic        lvl;
    logic        rise;
    logic [14:0] presc;
    logic [15:0] lim;
    logic        measuring;
    logic        tick;
    logic        timeout;
    logic [7:0]  cnt_p, cnt_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= lvl;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic f0, f1, filt;

    // Level moves only once three consecutive synchronized samples agree.
    assign lvl = (s2 == f0 && f0 == f1) ? s2 : filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f0   <= 1'b0;
            f1   <= 1'b0;
            filt <= 1'b0;
        end else begin
            f0   <= s2;
            f1   <= f0;
            filt <= lvl;
        end
    end
`else
    assign lvl = s2;
`endif

    assign rise      = lvl & ~s3;
    assign lim       = (16'd1 << prescale_div) - 16'd1;
    assign measuring = enable && (state == MEASURE);
    assign tick      = measuring && (presc == lim[14:0]);
    assign timeout   = tick && (cnt_p == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!measuring || rise || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt_p        <= '0;
            cnt_h        <= '0;
            high_time    <= '0;
            period       <= '0;
            sample_valid <= 1'b0;
            level_static <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt_p <= '0;
                cnt_h <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt_p <= '0;
                        cnt_h <= '0;
                        if (rise) begin
                            state        <= MEASURE;
                            level_static <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        // Timeout takes priority over a coincident edge.
                        if (timeout) begin
                            period       <= 8'hFF;
                            high_time    <= s3 ? 8'hFF : 8'h00;
                            sample_valid <= 1'b1;
                            level_static <= 1'b1;
                            state        <= IDLE;
                            cnt_p        <= '0;
                            cnt_h        <= '0;
                        end else if (rise) begin
                            period       <= cnt_p + {7'd0, tick};
                            high_time    <= cnt_h;
                            sample_valid <= 1'b1;
                            cnt_p        <= '0;
                            cnt_h        <= '0;
                        end else if (tick) begin
                            cnt_p <= cnt_p + 8'd1;
                            cnt_h <= cnt_h + {7'd0, s3};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (timeout) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
